// File: rtl/weight_loader.sv
// Weight RAM loader: pulls signed weights over valid/ready, optionally saturates them,
// stores NUM_WEIGHTS words and serves them back through a registered read port.
module weight_loader #(
    parameter int                         DATA_W      = 16,
    parameter int                         NUM_WEIGHTS = 16,
    parameter int                         ADDR_W      = 4,
    parameter bit                         CLAMP_EN    = 1'b1,
    parameter logic signed [DATA_W-1:0]   CLAMP_MAG   = 16'sh4000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              w_in_valid,
    input  logic [DATA_W-1:0] w_in,
    output logic              w_in_ready,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   clamp_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0]        LAST_ADDR = ADDR_W'(NUM_WEIGHTS - 1);
    localparam logic [ADDR_W:0]          NUM_W     = (ADDR_W + 1)'(NUM_WEIGHTS);
    localparam logic signed [DATA_W-1:0] NEG_MAG   = -CLAMP_MAG;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [ADDR_W:0]     clamp_count_q, clamp_count_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]   mem [2**ADDR_W];

    logic                transfer;
    logic                sat_hit;
    logic [DATA_W-1:0]   w_sat;

    always_comb begin
        w_sat   = w_in;
        sat_hit = 1'b0;
        if (CLAMP_EN) begin
            if ($signed(w_in) > CLAMP_MAG) begin
                w_sat   = CLAMP_MAG;
                sat_hit = 1'b1;
            end else if ($signed(w_in) < NEG_MAG) begin
                w_sat   = NEG_MAG;
                sat_hit = 1'b1;
            end
        end
    end

    // Ready is a pure state decode, so valid never feeds back into ready.
    assign transfer = (state_q == S_LOAD) && w_in_valid;

    always_comb begin
        state_d       = state_q;
        wr_addr_d     = wr_addr_q;
        clamp_count_d = clamp_count_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d       = S_LOAD;
                    wr_addr_d     = '0;
                    clamp_count_d = '0;
                end
            end
            S_LOAD: begin
                if (transfer) begin
                    wr_addr_d = wr_addr_q + 1'b1;
                    if (sat_hit && (clamp_count_q != '1)) begin
                        clamp_count_d = clamp_count_q + 1'b1;
                    end
                    if (wr_addr_q == LAST_ADDR) begin
                        state_d   = S_DONE;
                        wr_addr_d = '0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Read samples the array before this edge's write lands: read-before-write.
    always_comb begin
        rd_valid_d = rd_en;
        rd_data_d  = rd_data_q;
        if (rd_en) begin
            rd_data_d = ({1'b0, rd_addr} < NUM_W) ? mem[rd_addr] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            wr_addr_q     <= '0;
            clamp_count_q <= '0;
            rd_data_q     <= '0;
            rd_valid_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_addr_q     <= wr_addr_d;
            clamp_count_q <= clamp_count_d;
            rd_data_q     <= rd_data_d;
            rd_valid_q    <= rd_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && transfer) begin
            mem[wr_addr_q] <= w_sat;
        end
    end

    assign w_in_ready  = (state_q == S_LOAD);
    assign busy        = (state_q == S_LOAD);
    assign done        = (state_q == S_DONE);
    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign clamp_count = clamp_count_q;

endmodule

// File: tb/tb_weight_loader.sv
// Randomized self-checking bench for weight_loader against a behavioural load/read model.
module tb_weight_loader;

    localparam int NW = 16;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, w_in_valid, w_in_ready, rd_en, rd_valid, busy, done;
    logic [15:0] w_in, rd_data;
    logic [3:0]  rd_addr;
    logic [4:0]  clamp_count;

    logic        b_rst, b_start, b_w_in_valid, b_w_in_ready, b_rd_en, b_rd_valid, b_busy, b_done;
    logic [15:0] b_w_in, b_rd_data;
    logic [3:0]  b_rd_addr;
    logic [4:0]  b_clamp_count;

    weight_loader #(
        .DATA_W(16), .NUM_WEIGHTS(16), .ADDR_W(4), .CLAMP_EN(1'b1), .CLAMP_MAG(16'sh4000)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .w_in_valid(w_in_valid), .w_in(w_in),
        .w_in_ready(w_in_ready), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_valid(rd_valid), .busy(busy), .done(done), .clamp_count(clamp_count)
    );

    weight_loader #(
        .DATA_W(16), .NUM_WEIGHTS(12), .ADDR_W(4), .CLAMP_EN(1'b0), .CLAMP_MAG(16'sh4000)
    ) dut12 (
        .clk(clk), .rst(b_rst), .start(b_start), .w_in_valid(b_w_in_valid), .w_in(b_w_in),
        .w_in_ready(b_w_in_ready), .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
        .rd_valid(b_rd_valid), .busy(b_busy), .done(b_done), .clamp_count(b_clamp_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model of the 16-word clamped instance.
    logic [15:0] m_mem [NW];
    int          m_phase;   // 0 idle, 1 loading, 2 done
    int          m_cnt;
    int          m_clamp;
    logic        m_rdv;
    logic [15:0] m_rdd;

    function automatic logic [15:0] sat_ref(input logic [15:0] x);
        int v;
        v = $signed(x);
        if (v > 16384)  return 16'h4000;
        if (v < -16384) return 16'hC000;
        return x;
    endfunction

    task automatic idle_inputs();
        rst = 1'b0; start = 1'b0; w_in_valid = 1'b0; w_in = '0; rd_en = 1'b0; rd_addr = '0;
        b_rst = 1'b0; b_start = 1'b0; b_w_in_valid = 1'b0; b_w_in = '0; b_rd_en = 1'b0; b_rd_addr = '0;
    endtask

    // Advance one clock, updating the model from the inputs currently driven.
    task automatic step();
        logic [15:0] s;
        if (rst) begin
            m_phase = 0; m_cnt = 0; m_clamp = 0; m_rdv = 1'b0; m_rdd = '0;
        end else begin
            if (rd_en) begin
                m_rdv = 1'b1;
                m_rdd = (int'(rd_addr) < NW) ? m_mem[rd_addr] : 16'h0000;
            end else begin
                m_rdv = 1'b0;
            end
            if (m_phase == 1 && w_in_valid) begin
                s = sat_ref(w_in);
                if (s !== w_in && m_clamp < 31) m_clamp++;
                m_mem[m_cnt] = s;
                m_cnt++;
                if (m_cnt == NW) begin
                    m_phase = 2;
                    m_cnt   = 0;
                end
            end else if (m_phase != 1 && start) begin
                m_phase = 1; m_cnt = 0; m_clamp = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1; b_rst = 1'b1;
        step(); step();
        rst = 1'b0; b_rst = 1'b0;
        n_checks++;
        if ({w_in_ready, busy, done, rd_valid} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags got %b want 0000", {w_in_ready, busy, done, rd_valid});
        end
        n_checks++;
        if (rd_data !== 16'h0000 || clamp_count !== 5'd0) begin
            n_fail++; $display("FAIL reset_data got rd_data=%h clamp=%0d want 0/0", rd_data, clamp_count);
        end
        n_checks++;
        if ({b_w_in_ready, b_busy, b_done, b_rd_valid} !== 4'b0000 || b_rd_data !== 16'h0000) begin
            n_fail++; $display("FAIL reset_dut12 got flags=%b data=%h want 0000/0000",
                               {b_w_in_ready, b_busy, b_done, b_rd_valid}, b_rd_data);
        end
        step();
        n_checks++;
        if (w_in_ready !== 1'b0) begin
            n_fail++; $display("FAIL idle_ready got %b want 0", w_in_ready);
        end
    endtask

    task automatic test_stream();
        start = 1'b1; step(); start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || w_in_ready !== 1'b1) begin
            n_fail++; $display("FAIL stream_enter_load got busy=%b ready=%b want 1/1", busy, w_in_ready);
        end
        for (int i = 0; i < NW; i++) begin
            w_in_valid = 1'b1; w_in = 16'(i + 1);
            step();
            n_checks++;
            if (done !== (m_phase == 2) || busy !== (m_phase == 1)) begin
                n_fail++; $display("FAIL stream_word%0d got busy=%b done=%b want %b/%b",
                                   i, busy, done, m_phase == 1, m_phase == 2);
            end
        end
        w_in_valid = 1'b0;
        n_checks++;
        if (done !== 1'b1 || clamp_count !== 5'd0) begin
            n_fail++; $display("FAIL stream_done got done=%b clamp=%0d want 1/0", done, clamp_count);
        end
        for (int a = 0; a < NW; a++) begin
            rd_en = 1'b1; rd_addr = 4'(a);
            step();
            n_checks++;
            if (rd_valid !== 1'b1 || rd_data !== 16'(a + 1)) begin
                n_fail++; $display("FAIL stream_read%0d got v=%b d=%h want 1/%h", a, rd_valid, rd_data, 16'(a + 1));
            end
        end
        rd_en = 1'b0; step();
        n_checks++;
        if (rd_valid !== 1'b0 || rd_data !== 16'h0010) begin
            n_fail++; $display("FAIL read_hold got v=%b d=%h want 0/0010", rd_valid, rd_data);
        end
    endtask

    task automatic test_clamp();
        logic [15:0] lead [5];
        logic [15:0] want [5];
        lead = '{16'h7FFF, 16'h8000, 16'h4000, 16'hC000, 16'h1234};
        want = '{16'h4000, 16'hC000, 16'h4000, 16'hC000, 16'h1234};
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < NW; i++) begin
            w_in_valid = 1'b1;
            w_in = (i < 5) ? lead[i] : 16'($urandom);
            step();
            if (i == 4) begin
                n_checks++;
                if (clamp_count !== 5'd2) begin
                    n_fail++; $display("FAIL clamp_count_5 got %0d want 2", clamp_count);
                end
            end
        end
        w_in_valid = 1'b0;
        n_checks++;
        if (done !== 1'b1 || clamp_count !== 5'(m_clamp)) begin
            n_fail++; $display("FAIL clamp_total got done=%b clamp=%0d want 1/%0d", done, clamp_count, m_clamp);
        end
        for (int a = 0; a < NW; a++) begin
            rd_en = 1'b1; rd_addr = 4'(a);
            step();
            n_checks++;
            if (rd_data !== m_rdd || (a < 5 && rd_data !== want[a])) begin
                n_fail++; $display("FAIL clamp_read%0d got %h want %h", a, rd_data, m_rdd);
            end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_valid_gaps();
        int acc = 0;
        int cyc = 0;
        start = 1'b1; step(); start = 1'b0;
        while (m_phase == 1 && cyc < 300) begin
            w_in_valid = (cyc % 3 == 0) ? 1'b1 : 1'($urandom_range(0, 3) == 0);
            w_in = 16'($urandom);
            if (w_in_valid) acc++;
            step();
            cyc++;
            n_checks++;
            if (done !== (acc == NW) || busy !== (acc < NW)) begin
                n_fail++; $display("FAIL gaps_cycle%0d got busy=%b done=%b accepted=%0d", cyc, busy, done, acc);
            end
        end
        w_in_valid = 1'b0;
        n_checks++;
        if (m_phase != 2 || done !== 1'b1) begin
            n_fail++; $display("FAIL gaps_timeout got done=%b after %0d cycles want 1", done, cyc);
        end
        for (int a = 0; a < NW; a++) begin
            rd_en = 1'b1; rd_addr = 4'(a);
            step();
            n_checks++;
            if (rd_valid !== 1'b1 || rd_data !== m_rdd) begin
                n_fail++; $display("FAIL gaps_read%0d got %h want %h", a, rd_data, m_rdd);
            end
        end
        n_checks++;
        if (clamp_count !== 5'(m_clamp)) begin
            n_fail++; $display("FAIL gaps_clamp got %0d want %0d", clamp_count, m_clamp);
        end
        rd_en = 1'b0;
    endtask

    task automatic test_reset_mid_load();
        logic [15:0] prev [NW];
        prev = m_mem;
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            w_in_valid = 1'b1; w_in = 16'($urandom_range(0, 16'h3FFF));
            step();
        end
        rst = 1'b1; step(); rst = 1'b0;
        w_in_valid = 1'b1;
        n_checks++;
        if ({w_in_ready, busy, done} !== 3'b000 || clamp_count !== 5'd0) begin
            n_fail++; $display("FAIL midreset_state got rbd=%b clamp=%0d want 000/0", {w_in_ready, busy, done}, clamp_count);
        end
        w_in_valid = 1'b0;
        for (int a = 0; a < NW; a++) begin
            rd_en = 1'b1; rd_addr = 4'(a);
            step();
            n_checks++;
            if (rd_data !== m_rdd || (a >= 7 && rd_data !== prev[a])) begin
                n_fail++; $display("FAIL midreset_read%0d got %h want %h", a, rd_data, m_rdd);
            end
        end
        rd_en = 1'b0;
        rst = 1'b1; start = 1'b1; step(); rst = 1'b0; start = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL rst_beats_start got busy=%b want 0", busy);
        end
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < NW; i++) begin
            w_in_valid = 1'b1; w_in = 16'($urandom);
            step();
        end
        w_in_valid = 1'b0;
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++; $display("FAIL reload_after_reset got done=%b want 1", done);
        end
        rd_en = 1'b1; rd_addr = 4'd0; step(); rd_en = 1'b0;
        n_checks++;
        if (rd_data !== m_rdd) begin
            n_fail++; $display("FAIL reload_addr0 got %h want %h", rd_data, m_rdd);
        end
    endtask

    task automatic test_start_behaviour();
        start = 1'b1; step(); start = 1'b0;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL start_in_done got done=%b busy=%b want 0/1", done, busy);
        end
        for (int i = 0; i < 5; i++) begin
            w_in_valid = 1'b1; w_in = 16'($urandom);
            step();
        end
        w_in_valid = 1'b0; start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 11; i++) begin
            w_in_valid = 1'b1; w_in = 16'($urandom);
            rd_en = 1'b1; rd_addr = 4'($urandom_range(0, 15));
            step();
            n_checks++;
            if (done !== (i == 10) || rd_data !== m_rdd) begin
                n_fail++; $display("FAIL midload_start%0d got done=%b rd=%h want %b/%h", i, done, rd_data, i == 10, m_rdd);
            end
        end
        w_in_valid = 1'b0; rd_en = 1'b0;
        for (int a = 0; a < NW; a++) begin
            rd_en = 1'b1; rd_addr = 4'(a);
            step();
            n_checks++;
            if (rd_data !== m_rdd) begin
                n_fail++; $display("FAIL midload_read%0d got %h want %h", a, rd_data, m_rdd);
            end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_rbw_and_range();
        logic [15:0] exp12 [12];
        int cyc = 0;
        b_start = 1'b1; step(); b_start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            exp12[i] = (i == 3) ? 16'h5555 : 16'($urandom);
            b_w_in_valid = 1'b1; b_w_in = exp12[i];
            step();
        end
        b_w_in_valid = 1'b0;
        n_checks++;
        if (b_done !== 1'b1 || b_busy !== 1'b0) begin
            n_fail++; $display("FAIL nw12_done got done=%b busy=%b want 1/0", b_done, b_busy);
        end
        b_rd_en = 1'b1; b_rd_addr = 4'd15; step();
        n_checks++;
        if (b_rd_valid !== 1'b1 || b_rd_data !== 16'h0000) begin
            n_fail++; $display("FAIL out_of_range got v=%b d=%h want 1/0000", b_rd_valid, b_rd_data);
        end
        b_rd_addr = 4'd11; step();
        n_checks++;
        if (b_rd_data !== exp12[11]) begin
            n_fail++; $display("FAIL nw12_last got %h want %h", b_rd_data, exp12[11]);
        end
        b_rd_en = 1'b0;
        b_start = 1'b1; step(); b_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            b_w_in_valid = 1'b1; b_w_in = 16'($urandom);
            step();
        end
        b_w_in = 16'hAAAA; b_rd_en = 1'b1; b_rd_addr = 4'd3;
        step();
        n_checks++;
        if (b_rd_data !== 16'h5555) begin
            n_fail++; $display("FAIL read_before_write got %h want 5555", b_rd_data);
        end
        b_w_in_valid = 1'b0;
        step();
        n_checks++;
        if (b_rd_data !== 16'hAAAA || b_rd_valid !== 1'b1) begin
            n_fail++; $display("FAIL read_after_write got v=%b d=%h want 1/aaaa", b_rd_valid, b_rd_data);
        end
        b_rd_en = 1'b0;
        b_w_in_valid = 1'b1;
        while (b_done !== 1'b1 && cyc < 50) begin
            b_w_in = 16'($urandom);
            step();
            cyc++;
        end
        b_w_in_valid = 1'b0;
        n_checks++;
        if (cyc != 8) begin
            n_fail++; $display("FAIL nw12_reload_len got %0d more words want 8", cyc);
        end
    endtask

    initial begin
        idle_inputs();
        m_phase = 0; m_cnt = 0; m_clamp = 0; m_rdv = 1'b0; m_rdd = '0;
        test_reset();
        test_stream();
        test_clamp();
        test_valid_gaps();
        test_reset_mid_load();
        test_start_behaviour();
        test_rbw_and_range();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
